// File: rtl/maze_draw_arbiter.sv
// maze_draw_arbiter: shares one VGA plot port between three pixel sources
// (0 = maze cell renderer, 1 = player sprite, 2 = win/lose screen).
// The port is granted to one source for a whole burst, which ends on a last
// pixel, when the owner drops req, or when the watchdog expires. Grants rotate
// round-robin. There is always one idle cycle between bursts.
// Ports:
//   clk, resetn           clock (rising edge), async active-low reset
//   req[2:0]              per-source request, held for the whole burst
//   pix_valid/pix_last    per-source pixel strobe and end-of-burst flag
//   pix_x/pix_y/pix_col   packed per-source fields, source i at [i*W +: W]
//   gnt[2:0]              registered one-hot grant
//   plot, vga_x, vga_y,
//   colour                registered VGA adapter write port
//   busy                  high while a burst is in progress
//   timeout               one-cycle pulse when the watchdog forces a release
module maze_draw_arbiter #(
  parameter int unsigned XW      = 8,
  parameter int unsigned YW      = 7,
  parameter int unsigned CW      = 3,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [2:0]      req,
  input  logic [2:0]      pix_valid,
  input  logic [2:0]      pix_last,
  input  logic [3*XW-1:0] pix_x,
  input  logic [3*YW-1:0] pix_y,
  input  logic [3*CW-1:0] pix_col,
  output logic [2:0]      gnt,
  output logic            plot,
  output logic [XW-1:0]   vga_x,
  output logic [YW-1:0]   vga_y,
  output logic [CW-1:0]   colour,
  output logic            busy,
  output logic            timeout
);

  localparam int unsigned WDW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT - 1);

  typedef enum logic {IDLE, BURST} state_e;

  state_e          state_q, state_d;
  logic [1:0]      owner_q, owner_d;
  logic [1:0]      last_owner_q, last_owner_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic [2:0]      gnt_q, gnt_d;
  logic            plot_q, plot_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [CW-1:0]   col_q, col_d;
  logic            busy_q, busy_d;
  logic            timeout_q, timeout_d;

  // Owner's view of the source buses; everything else is ignored.
  logic            k_req, k_valid, k_last;
  logic [XW-1:0]   k_x;
  logic [YW-1:0]   k_y;
  logic [CW-1:0]   k_col;

  // First requester after the previous owner, in circular order.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] pick;
    case (last)
      2'd0:    pick = r[1] ? 2'd1 : (r[2] ? 2'd2 : 2'd0);
      2'd1:    pick = r[2] ? 2'd2 : (r[0] ? 2'd0 : 2'd1);
      default: pick = r[0] ? 2'd0 : (r[1] ? 2'd1 : 2'd2);
    endcase
    return pick;
  endfunction

  // Select the current owner's inputs.
  always_comb begin
    k_req   = 1'b0;
    k_valid = 1'b0;
    k_last  = 1'b0;
    k_x     = '0;
    k_y     = '0;
    k_col   = '0;
    case (owner_q)
      2'd0: begin
        k_req = req[0]; k_valid = pix_valid[0]; k_last = pix_last[0];
        k_x = pix_x[0 +: XW]; k_y = pix_y[0 +: YW]; k_col = pix_col[0 +: CW];
      end
      2'd1: begin
        k_req = req[1]; k_valid = pix_valid[1]; k_last = pix_last[1];
        k_x = pix_x[XW +: XW]; k_y = pix_y[YW +: YW]; k_col = pix_col[CW +: CW];
      end
      2'd2: begin
        k_req = req[2]; k_valid = pix_valid[2]; k_last = pix_last[2];
        k_x = pix_x[2*XW +: XW]; k_y = pix_y[2*YW +: YW]; k_col = pix_col[2*CW +: CW];
      end
      default: ;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    wd_d         = wd_q;
    gnt_d        = gnt_q;
    plot_d       = 1'b0;
    x_d          = x_q;
    y_d          = y_q;
    col_d        = col_q;
    busy_d       = busy_q;
    timeout_d    = 1'b0;

    case (state_q)
      IDLE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (req != 3'b000) begin
          owner_d = rr_pick(req, last_owner_q);
          gnt_d   = 3'b001 << owner_d;
          busy_d  = 1'b1;
          wd_d    = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        plot_d = k_valid;
        if (k_valid) begin
          x_d   = k_x;
          y_d   = k_y;
          col_d = k_col;
          wd_d  = '0;
        end else if (wd_q != {WDW{1'b1}}) begin
          wd_d = wd_q + WDW'(1);
        end
        // Release priority: dropped request, last pixel, then watchdog.
        if (!k_req || (k_valid && k_last) || (!k_valid && wd_q == WD_LIMIT)) begin
          timeout_d    = k_req && !k_valid;
          gnt_d        = '0;
          busy_d       = 1'b0;
          last_owner_d = owner_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      owner_q      <= 2'd0;
      last_owner_q <= 2'd2;
      wd_q         <= '0;
      gnt_q        <= '0;
      plot_q       <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      col_q        <= '0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      wd_q         <= wd_d;
      gnt_q        <= gnt_d;
      plot_q       <= plot_d;
      x_q          <= x_d;
      y_q          <= y_d;
      col_q        <= col_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign plot    = plot_q;
  assign vga_x   = x_q;
  assign vga_y   = y_q;
  assign colour  = col_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_maze_draw_arbiter.sv
// Directed bench for maze_draw_arbiter: a cycle-by-cycle vector table plus
// hand-written watchdog and mid-burst reset sequences.
module tb_maze_draw_arbiter;

  localparam int unsigned XW = 8;
  localparam int unsigned YW = 7;
  localparam int unsigned CW = 3;
  localparam int unsigned TO = 16;

  logic            clk = 1'b0;
  logic            resetn;
  logic [2:0]      req, pix_valid, pix_last;
  logic [3*XW-1:0] pix_x;
  logic [3*YW-1:0] pix_y;
  logic [3*CW-1:0] pix_col;
  logic [2:0]      gnt;
  logic            plot, busy, timeout;
  logic [XW-1:0]   vga_x;
  logic [YW-1:0]   vga_y;
  logic [CW-1:0]   colour;

  int checks   = 0;
  int failures = 0;

  maze_draw_arbiter #(.XW(XW), .YW(YW), .CW(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .req(req), .pix_valid(pix_valid),
    .pix_last(pix_last), .pix_x(pix_x), .pix_y(pix_y), .pix_col(pix_col),
    .gnt(gnt), .plot(plot), .vga_x(vga_x), .vga_y(vga_y), .colour(colour),
    .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]      req, valid, last;
    logic [3*XW-1:0] px;
    logic [3*YW-1:0] py;
    logic [3*CW-1:0] pc;
    logic [2:0]      e_gnt;
    logic            e_plot;
    logic [XW-1:0]   e_x;
    logic [YW-1:0]   e_y;
    logic [CW-1:0]   e_c;
    logic            e_busy, e_to;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [2:0] r, input logic [2:0] v, input logic [2:0] l,
                     input logic [3*XW-1:0] px, input logic [3*YW-1:0] py,
                     input logic [3*CW-1:0] pc, input logic [2:0] eg, input logic ep,
                     input logic [XW-1:0] ex, input logic [YW-1:0] ey,
                     input logic [CW-1:0] ec, input logic eb, input logic et);
    vec_t t;
    t.req = r; t.valid = v; t.last = l; t.px = px; t.py = py; t.pc = pc;
    t.e_gnt = eg; t.e_plot = ep; t.e_x = ex; t.e_y = ey; t.e_c = ec;
    t.e_busy = eb; t.e_to = et;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] eg, input logic ep,
                           input logic [XW-1:0] ex, input logic [YW-1:0] ey,
                           input logic [CW-1:0] ec, input logic eb, input logic et);
    check({tag, " gnt"},     32'(gnt),     32'(eg));
    check({tag, " plot"},    32'(plot),    32'(ep));
    check({tag, " vga_x"},   32'(vga_x),   32'(ex));
    check({tag, " vga_y"},   32'(vga_y),   32'(ey));
    check({tag, " colour"},  32'(colour),  32'(ec));
    check({tag, " busy"},    32'(busy),    32'(eb));
    check({tag, " timeout"}, 32'(timeout), 32'(et));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req = '0; pix_valid = '0; pix_last = '0; pix_x = '0; pix_y = '0; pix_col = '0;
  endtask

  initial begin
    // Inputs applied in one cycle; registered response checked after the next edge.
    add(3'b111, 3'b000, 3'b000, '0, '0, '0,                                   3'b001, 0, 0, 0, 0, 1, 0);
    add(3'b111, 3'b111, 3'b000, {8'd120, 8'd99, 8'd5}, {7'd90, 7'd50, 7'd7},
        {3'd7, 3'd6, 3'd3},                                                   3'b001, 1, 5, 7, 3, 1, 0);
    add(3'b111, 3'b001, 3'b001, {8'd0, 8'd0, 8'd6}, {7'd0, 7'd0, 7'd7},
        {3'd0, 3'd0, 3'd3},                                                   3'b000, 1, 6, 7, 3, 0, 0);
    add(3'b111, 3'b000, 3'b000, '0, '0, '0,                                   3'b010, 0, 6, 7, 3, 1, 0);
    add(3'b111, 3'b010, 3'b000, {8'd0, 8'd10, 8'd0}, {7'd0, 7'd20, 7'd0},
        {3'd0, 3'd5, 3'd0},                                                   3'b010, 1, 10, 20, 5, 1, 0);
    add(3'b111, 3'b010, 3'b010, {8'd0, 8'd11, 8'd0}, {7'd0, 7'd20, 7'd0},
        {3'd0, 3'd5, 3'd0},                                                   3'b000, 1, 11, 20, 5, 0, 0);
    add(3'b111, 3'b000, 3'b000, '0, '0, '0,                                   3'b100, 0, 11, 20, 5, 1, 0);
    add(3'b111, 3'b100, 3'b000, {8'd30, 8'd0, 8'd0}, {7'd40, 7'd0, 7'd0},
        {3'd6, 3'd0, 3'd0},                                                   3'b100, 1, 30, 40, 6, 1, 0);
    add(3'b111, 3'b100, 3'b100, {8'd31, 8'd0, 8'd0}, {7'd40, 7'd0, 7'd0},
        {3'd6, 3'd0, 3'd0},                                                   3'b000, 1, 31, 40, 6, 0, 0);
    add(3'b111, 3'b000, 3'b000, '0, '0, '0,                                   3'b001, 0, 31, 40, 6, 1, 0);
    // Owner 0 drops req with a valid pixel: pixel still plotted, burst ends.
    add(3'b110, 3'b001, 3'b000, {8'd0, 8'd0, 8'd1}, {7'd0, 7'd0, 7'd2},
        {3'd0, 3'd0, 3'd1},                                                   3'b000, 1, 1, 2, 1, 0, 0);
    add(3'b100, 3'b000, 3'b000, '0, '0, '0,                                   3'b100, 0, 1, 2, 1, 1, 0);
    add(3'b101, 3'b100, 3'b000, {8'd50, 8'd0, 8'd0}, {7'd60, 7'd0, 7'd0},
        {3'd2, 3'd0, 3'd0},                                                   3'b100, 1, 50, 60, 2, 1, 0);
    // Src2 drops req; later stray src2 pixels must never reach the VGA port.
    add(3'b001, 3'b000, 3'b000, '0, '0, '0,                                   3'b000, 0, 50, 60, 2, 0, 0);
    add(3'b001, 3'b100, 3'b000, {8'd77, 8'd0, 8'd0}, {7'd33, 7'd0, 7'd0},
        {3'd5, 3'd0, 3'd0},                                                   3'b001, 0, 50, 60, 2, 1, 0);
    add(3'b001, 3'b100, 3'b000, {8'd77, 8'd0, 8'd0}, {7'd33, 7'd0, 7'd0},
        {3'd5, 3'd0, 3'd0},                                                   3'b001, 0, 50, 60, 2, 1, 0);
    add(3'b000, 3'b000, 3'b000, '0, '0, '0,                                   3'b000, 0, 50, 60, 2, 0, 0);
    add(3'b000, 3'b000, 3'b000, '0, '0, '0,                                   3'b000, 0, 50, 60, 2, 0, 0);

    idle_inputs();
    resetn = 1'b0;
    #12;
    check_all("reset", 3'b000, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      req = vecs[i].req; pix_valid = vecs[i].valid; pix_last = vecs[i].last;
      pix_x = vecs[i].px; pix_y = vecs[i].py; pix_col = vecs[i].pc;
      step();
      check_all($sformatf("vec%0d", i), vecs[i].e_gnt, vecs[i].e_plot, vecs[i].e_x,
                vecs[i].e_y, vecs[i].e_c, vecs[i].e_busy, vecs[i].e_to);
    end

    // Watchdog: src1 granted (last owner 0), never presents a pixel; src2 waits.
    idle_inputs();
    req = 3'b110;
    step();
    check("wd grant", 32'(gnt), 32'(3'b010));
    for (int i = 0; i < int'(TO) - 1; i++) step();
    check("wd hold gnt", 32'(gnt), 32'(3'b010));
    check("wd hold timeout", 32'(timeout), 32'(0));
    step();
    check("wd fire timeout", 32'(timeout), 32'(1));
    check("wd fire gnt", 32'(gnt), 32'(3'b000));
    check("wd fire busy", 32'(busy), 32'(0));
    check("wd fire plot", 32'(plot), 32'(0));
    step();
    check("wd pulse end", 32'(timeout), 32'(0));
    check("wd next gnt", 32'(gnt), 32'(3'b100));
    req = 3'b000;
    step();
    check("wd src2 release", 32'(gnt), 32'(3'b000));

    // Mid-burst reset: leave last owner at 0, grant src1, emit a pixel, reset.
    req = 3'b001;
    step();
    check("rst pre gnt0", 32'(gnt), 32'(3'b001));
    req = 3'b000;
    step();
    req = 3'b010;
    step();
    check("rst pre gnt1", 32'(gnt), 32'(3'b010));
    pix_valid = 3'b010;
    pix_x = {8'd0, 8'd44, 8'd0}; pix_y = {7'd0, 7'd22, 7'd0}; pix_col = {3'd0, 3'd4, 3'd0};
    step();
    check_all("rst pre pix", 3'b010, 1, 44, 22, 4, 1, 0);
    resetn = 1'b0;
    #2;
    check_all("rst async", 3'b000, 0, 0, 0, 0, 0, 0);
    idle_inputs();
    @(negedge clk);
    resetn = 1'b1;
    req = 3'b111;
    step();
    check("rst first gnt", 32'(gnt), 32'(3'b001));
    check("rst no plot", 32'(plot), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
